// File: rtl/freq_meter.sv
// Gated edge counter: counts sig_in rising edges over GATE_CYCLES clocks and shows the count on two 7-segment digits.
// Define FREQ_METER_BLANK_EN to blank a leading-zero tens digit.
module freq_meter #(
    parameter int GATE_CYCLES = 50,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sig_in,
    output logic [CNT_W-1:0] meas_bin,
    output logic             meas_valid,
    output logic             over_range,
    output logic [6:0]       SEG_FREQ,
    output logic [6:0]       SEG_FREQ1
);

    // state | meaning
    // GATE  | counting synchronized rising edges for GATE_CYCLES clocks
    // CONV  | splitting the count into tens/units by repeated subtraction
    // SHOW  | publishing results for one cycle, then back to GATE
    localparam logic [1:0] ST_GATE = 2'd0;
    localparam logic [1:0] ST_CONV = 2'd1;
    localparam logic [1:0] ST_SHOW = 2'd2;

    localparam int               TMR_W    = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TEN      = CNT_W'(10);
    localparam logic [6:0]       SEG_DASH  = 7'b0111111;
    localparam logic [6:0]       SEG_ZERO  = 7'b1000000;
    localparam logic [6:0]       SEG_BLANK = 7'b1111111;
`ifdef FREQ_METER_BLANK_EN
    localparam logic [6:0]       SEG1_RST = SEG_BLANK;
`else
    localparam logic [6:0]       SEG1_RST = SEG_ZERO;
`endif

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_DASH;
        endcase
        return s;
    endfunction

    logic             sync1_q, sync2_q, prev_q;
    logic [1:0]       state_q, state_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
    logic [CNT_W-1:0] resid_q, resid_d;
    logic [3:0]       tens_q, tens_d;
    logic [CNT_W-1:0] bin_q, bin_d;
    logic             valid_q, valid_d;
    logic             over_q, over_d;
    logic [6:0]       seg0_q, seg0_d;
    logic [6:0]       seg1_q, seg1_d;
    logic             edge_p;
    logic             over_w;

    assign edge_p = sync2_q & ~prev_q;
    // Ten subtractions only happen when the count reached at least 100.
    assign over_w = (tens_q == 4'd10);

    always_comb begin
        state_d    = state_q;
        tmr_d      = tmr_q;
        edge_cnt_d = edge_cnt_q;
        resid_d    = resid_q;
        tens_d     = tens_q;
        bin_d      = bin_q;
        valid_d    = 1'b0;
        over_d     = over_q;
        seg0_d     = seg0_q;
        seg1_d     = seg1_q;
        case (state_q)
            ST_GATE: begin
                if (edge_p && (edge_cnt_q != '1)) begin
                    edge_cnt_d = edge_cnt_q + 1'b1;
                end
                if (tmr_q == TMR_LAST) begin
                    tmr_d   = '0;
                    resid_d = edge_cnt_d;
                    tens_d  = '0;
                    state_d = ST_CONV;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            ST_CONV: begin
                if ((resid_q >= TEN) && (tens_q < 4'd10)) begin
                    resid_d = resid_q - TEN;
                    tens_d  = tens_q + 4'd1;
                end else begin
                    state_d = ST_SHOW;
                end
            end
            ST_SHOW: begin
                bin_d   = edge_cnt_q;
                valid_d = 1'b1;
                over_d  = over_w;
                seg0_d  = over_w ? SEG_DASH : seg7(resid_q[3:0]);
`ifdef FREQ_METER_BLANK_EN
                seg1_d  = over_w ? SEG_DASH :
                          (tens_q == 4'd0) ? SEG_BLANK : seg7(tens_q);
`else
                seg1_d  = over_w ? SEG_DASH : seg7(tens_q);
`endif
                edge_cnt_d = '0;
                resid_d    = '0;
                tens_d     = '0;
                tmr_d      = '0;
                state_d    = ST_GATE;
            end
            default: state_d = ST_GATE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            prev_q     <= 1'b0;
            state_q    <= ST_GATE;
            tmr_q      <= '0;
            edge_cnt_q <= '0;
            resid_q    <= '0;
            tens_q     <= '0;
            bin_q      <= '0;
            valid_q    <= 1'b0;
            over_q     <= 1'b0;
            seg0_q     <= SEG_ZERO;
            seg1_q     <= SEG1_RST;
        end else begin
            sync1_q    <= sig_in;
            sync2_q    <= sync1_q;
            prev_q     <= sync2_q;
            state_q    <= state_d;
            tmr_q      <= tmr_d;
            edge_cnt_q <= edge_cnt_d;
            resid_q    <= resid_d;
            tens_q     <= tens_d;
            bin_q      <= bin_d;
            valid_q    <= valid_d;
            over_q     <= over_d;
            seg0_q     <= seg0_d;
            seg1_q     <= seg1_d;
        end
    end

    assign meas_bin   = bin_q;
    assign meas_valid = valid_q;
    assign over_range = over_q;
    assign SEG_FREQ   = seg0_q;
    assign SEG_FREQ1  = seg1_q;

endmodule

// File: tb/tb_freq_meter.sv
// Directed bench for freq_meter: default gate, a 500-cycle gate, and a 4-bit saturating counter instance.
module tb_freq_meter;

    localparam logic [6:0] S_0    = 7'b1000000;
    localparam logic [6:0] S_1    = 7'b1111001;
    localparam logic [6:0] S_2    = 7'b0100100;
    localparam logic [6:0] S_5    = 7'b0010010;
    localparam logic [6:0] S_DASH = 7'b0111111;
`ifdef FREQ_METER_BLANK_EN
    localparam logic [6:0] T_0 = 7'b1111111;
`else
    localparam logic [6:0] T_0 = 7'b1000000;
`endif

    logic clk, rst_n;
    logic sig_a, sig_b, sig_c;
    logic [7:0] bin_a, bin_b;
    logic [3:0] bin_c;
    logic valid_a, valid_b, valid_c;
    logic over_a, over_b, over_c;
    logic [6:0] s0_a, s1_a, s0_b, s1_b, s0_c, s1_c;

    int checks = 0;
    int failures = 0;
    int per_a = 0, per_b = 0, per_c = 0;
    int ph_a = 0, ph_b = 0, ph_c = 0;

    freq_meter dut_a (
        .clk(clk), .rst_n(rst_n), .sig_in(sig_a),
        .meas_bin(bin_a), .meas_valid(valid_a), .over_range(over_a),
        .SEG_FREQ(s0_a), .SEG_FREQ1(s1_a)
    );

    freq_meter #(.GATE_CYCLES(500), .CNT_W(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .sig_in(sig_b),
        .meas_bin(bin_b), .meas_valid(valid_b), .over_range(over_b),
        .SEG_FREQ(s0_b), .SEG_FREQ1(s1_b)
    );

    freq_meter #(.GATE_CYCLES(50), .CNT_W(4)) dut_c (
        .clk(clk), .rst_n(rst_n), .sig_in(sig_c),
        .meas_bin(bin_c), .meas_valid(valid_c), .over_range(over_c),
        .SEG_FREQ(s0_c), .SEG_FREQ1(s1_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Periodic test signals, changed away from the sampling edge.
    always @(posedge clk) begin
        #2;
        ph_a  = (ph_a + 1 >= per_a) ? 0 : ph_a + 1;
        sig_a = (per_a != 0) && (ph_a < per_a / 2);
        ph_b  = (ph_b + 1 >= per_b) ? 0 : ph_b + 1;
        sig_b = (per_b != 0) && (ph_b < per_b / 2);
        ph_c  = (ph_c + 1 >= per_c) ? 0 : ph_c + 1;
        sig_c = (per_c != 0) && (ph_c < per_c / 2);
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic wait_valid(input int which, input int budget, output int cyc);
        logic v;
        cyc = -1;
        for (int k = 1; k <= budget; k++) begin
            @(negedge clk);
            case (which)
                0:       v = valid_a;
                1:       v = valid_b;
                default: v = valid_c;
            endcase
            if (v) begin
                cyc = k;
                return;
            end
        end
        checks++;
        failures++;
        $display("FAIL wait_valid_%0d actual=timeout required=pulse", which);
    endtask

    typedef struct {
        int         per;
        int         bin;
        logic       over;
        logic [6:0] s0;
        logic [6:0] s1;
        int         gap;
    } vec_t;

    vec_t vecs[6];
    int cyc;

    initial begin
        vecs[0] = '{per: 0,  bin: 0,  over: 1'b0, s0: S_0, s1: T_0, gap: 52};
        vecs[1] = '{per: 5,  bin: 10, over: 1'b0, s0: S_0, s1: S_1, gap: 53};
        vecs[2] = '{per: 2,  bin: 25, over: 1'b0, s0: S_5, s1: S_2, gap: 54};
        vecs[3] = '{per: 10, bin: 5,  over: 1'b0, s0: S_5, s1: T_0, gap: 52};
        vecs[4] = '{per: 25, bin: 2,  over: 1'b0, s0: S_2, s1: T_0, gap: 52};
        vecs[5] = '{per: 50, bin: 1,  over: 1'b0, s0: S_1, s1: T_0, gap: 52};

        rst_n = 1'b0;
        sig_a = 1'b0; sig_b = 1'b0; sig_c = 1'b0;
        per_c = 2;
        repeat (3) @(negedge clk);
        chk("rst_bin", int'(bin_a), 0);
        chk("rst_valid", int'(valid_a), 0);
        chk("rst_over", int'(over_a), 0);
        chk("rst_seg0", int'(s0_a), int'(S_0));
        chk("rst_seg1", int'(s1_a), int'(T_0));
        chk("rst_seg1_big", int'(s1_b), int'(T_0));
        rst_n = 1'b1;

        // 4-bit counter: 25 edges saturate at 15.
        wait_valid(2, 200, cyc);
        wait_valid(2, 200, cyc);
        chk("sat_gap", cyc, 53);
        chk("sat_bin", int'(bin_c), 15);
        chk("sat_over", int'(over_c), 0);
        chk("sat_seg0", int'(s0_c), int'(S_5));
        chk("sat_seg1", int'(s1_c), int'(S_1));

        for (int i = 0; i < 6; i++) begin
            per_a = vecs[i].per;
            wait_valid(0, 200, cyc);
            wait_valid(0, 200, cyc);
            chk($sformatf("v%0d_gap", i), cyc, vecs[i].gap);
            chk($sformatf("v%0d_bin", i), int'(bin_a), vecs[i].bin);
            chk($sformatf("v%0d_over", i), int'(over_a), int'(vecs[i].over));
            chk($sformatf("v%0d_seg0", i), int'(s0_a), int'(vecs[i].s0));
            chk($sformatf("v%0d_seg1", i), int'(s1_a), int'(vecs[i].s1));
            @(negedge clk);
            chk($sformatf("v%0d_pulse", i), int'(valid_a), 0);
            chk($sformatf("v%0d_hold", i), int'(bin_a), vecs[i].bin);
        end

        // Abort a measurement with reset while the 10-count is converting.
        per_a = 5;
        wait_valid(0, 200, cyc);
        wait_valid(0, 200, cyc);
        chk("pre_rst_bin", int'(bin_a), 10);
        repeat (50) @(negedge clk);
        per_a = 0;
        rst_n = 1'b0;
        #1;
        chk("conv_rst_bin", int'(bin_a), 0);
        chk("conv_rst_seg0", int'(s0_a), int'(S_0));
        chk("conv_rst_seg1", int'(s1_a), int'(T_0));
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("conv_rst_valid", int'(valid_a), 0);
        end
        rst_n = 1'b1;
        wait_valid(0, 200, cyc);
        chk("post_rst_gap", cyc, 52);
        chk("post_rst_bin", int'(bin_a), 0);

        // 500-cycle gate: clk/2 overflows the display, then 50 fits.
        per_b = 2;
        wait_valid(1, 1200, cyc);
        wait_valid(1, 1200, cyc);
        chk("big_gap", cyc, 512);
        chk("big_bin", int'(bin_b), 250);
        chk("big_over", int'(over_b), 1);
        chk("big_seg0", int'(s0_b), int'(S_DASH));
        chk("big_seg1", int'(s1_b), int'(S_DASH));
        per_b = 10;
        wait_valid(1, 1200, cyc);
        wait_valid(1, 1200, cyc);
        chk("big2_gap", cyc, 507);
        chk("big2_bin", int'(bin_b), 50);
        chk("big2_over", int'(over_b), 0);
        chk("big2_seg0", int'(s0_b), int'(S_0));
        chk("big2_seg1", int'(s1_b), int'(S_5));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
